// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its digit cells.
package timer_pkg;

  localparam int DIGIT_W = 4;

  // Default moduli: digit0=10, digit1=6, digit2=10, digit3=6 (MM:SS).
  localparam logic [15:0] MMSS_MODS = 16'h6A6A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Command/status bundle between the tick/control side and the countdown timer.
interface bcd_countdown_timer_if #(
  parameter int NDIGITS = 4
) ();

  logic                                    ce;
  logic                                    stop;
  logic                                    load;
  logic                                    start;
  logic                                    pause;
  logic [timer_pkg::DIGIT_W*NDIGITS-1:0]   preset;
  logic [timer_pkg::DIGIT_W*NDIGITS-1:0]   count;
  logic                                    running;
  logic                                    done;

  modport master (
    output ce, stop, load, start, pause, preset,
    input  count, running, done
  );

  modport slave (
    input  ce, stop, load, start, pause, preset,
    output count, running, done
  );

endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One down-counting BCD digit with its own modulus; clamps loaded values to MOD-1.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               ld,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               zero
);

  localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(MOD - 1);

  function automatic logic [DIGIT_W-1:0] clamp(input logic [DIGIT_W-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  logic [DIGIT_W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= clamp(d);
    end else if (en) begin
      r_q <= (r_q == '0) ? MAXV : (r_q - DIGIT_W'(1));
    end
  end

  assign q    = r_q;
  assign zero = (r_q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: run/pause/done control, preset load, done pulse.
// Optional build macro TIMER_AUTORELOAD_EN reloads the last preset at zero instead of stopping.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int                         NDIGITS = 4,
  parameter logic [DIGIT_W*NDIGITS-1:0] MODS    = MMSS_MODS
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_countdown_timer_if.slave   bus
);

  timer_state_t r_state;
  timer_state_t w_state_nxt;
  logic         r_done;

  logic [NDIGITS-1:0]         w_zero;
  logic [NDIGITS-1:0]         w_en;
  logic [DIGIT_W*NDIGITS-1:0] w_count;
  logic [DIGIT_W*NDIGITS-1:0] w_digit_d;
  logic                       w_digit_ld;
  logic                       w_pause_eff;
  logic                       w_tick;
  logic                       w_term;
  logic                       w_count_zero;
  logic                       w_upper_zero;
  logic                       w_reload_now;

  // start outranks pause, so a pause only acts when start is absent
  assign w_pause_eff  = bus.pause & ~bus.start;
  assign w_tick       = (r_state == RUN) & bus.ce & ~bus.stop & ~bus.load & ~w_pause_eff;
  assign w_count_zero = &w_zero;
  assign w_upper_zero = &w_zero[NDIGITS-1:1];
  assign w_term       = w_tick & w_upper_zero & (w_count[DIGIT_W-1:0] == DIGIT_W'(1));

`ifdef TIMER_AUTORELOAD_EN
  // Raw preset is kept; the digits clamp it again on reload, giving the same value.
  logic [DIGIT_W*NDIGITS-1:0] r_reload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reload <= '0;
    end else if (bus.load && !bus.stop) begin
      r_reload <= bus.preset;
    end
  end

  assign w_reload_now = w_term & (r_reload != '0);
  assign w_digit_ld   = bus.load | w_reload_now;
  assign w_digit_d    = bus.load ? bus.preset : r_reload;
`else
  assign w_reload_now = 1'b0;
  assign w_digit_ld   = bus.load;
  assign w_digit_d    = bus.preset;
`endif

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsb
      assign w_en[i] = w_tick;
    end else begin : g_upper
      assign w_en[i] = w_tick & (&w_zero[i-1:0]);
    end

    bcd_down_digit #(
      .MOD (int'(MODS[DIGIT_W*i +: DIGIT_W]))
    ) u_digit (
      .clk   (clk),
      .reset (reset),
      .en    (w_en[i]),
      .ld    (w_digit_ld),
      .clr   (bus.stop),
      .d     (w_digit_d[DIGIT_W*i +: DIGIT_W]),
      .q     (w_count[DIGIT_W*i +: DIGIT_W]),
      .zero  (w_zero[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_term;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.stop || bus.load) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start && !w_count_zero) w_state_nxt = RUN;
        RUN: begin
          if (w_pause_eff)                   w_state_nxt = PAUSE;
          else if (w_term && !w_reload_now)  w_state_nxt = DONE;
        end
        PAUSE:   if (bus.start) w_state_nxt = RUN;
        DONE:    w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.count   = w_count;
  assign bus.running = (r_state == RUN);
  assign bus.done    = r_done;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: directed scenarios plus random commands vs. an integer model.
module tb_bcd_countdown_timer;
  import timer_pkg::*;

  localparam int          ND   = 4;
  localparam logic [15:0] MODS = MMSS_MODS;
`ifdef TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.NDIGITS(ND)) bus ();

  bcd_countdown_timer #(.NDIGITS(ND), .MODS(MODS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] count;
    logic        running;
    logic        done;
  } exp_t;

  exp_t q_exp[$];
  int   vectors = 0;
  int   errors  = 0;

  // Model: the count is one integer in mixed radix, stepping is plain subtraction.
  int m_val, m_reload, m_st;
  bit m_done;

  function automatic int mod_of(input int i);
    logic [15:0] m;
    m = MODS;
    return int'(m[4*i +: 4]);
  endfunction

  function automatic int to_val(input logic [15:0] bcd);
    int v, w, d;
    v = 0;
    w = 1;
    for (int i = 0; i < ND; i++) begin
      d = int'(bcd[4*i +: 4]);
      if (d > mod_of(i) - 1) d = mod_of(i) - 1;
      v += d * w;
      w *= mod_of(i);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int val);
    logic [15:0] r;
    int v;
    v = val;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % mod_of(i));
      v = v / mod_of(i);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val    = 0;
    m_reload = 0;
    m_st     = S_IDLE;
    m_done   = 1'b0;
  endtask

  task automatic model_step(input bit ce, stop, load, start, pause, input logic [15:0] preset);
    exp_t e;
    m_done = 1'b0;
    if (stop) begin
      m_val = 0;
      m_st  = S_IDLE;
    end else if (load) begin
      m_val    = to_val(preset);
      m_reload = m_val;
      m_st     = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE:  if (start && m_val != 0) m_st = S_RUN;
        S_RUN: begin
          if (pause && !start) m_st = S_PAUSE;
          else if (ce) begin
            if (m_val == 1) begin
              m_done = 1'b1;
              if (AR && m_reload != 0) m_val = m_reload;
              else begin
                m_val = 0;
                m_st  = S_DONE;
              end
            end else begin
              m_val = m_val - 1;
            end
          end
        end
        S_PAUSE: if (start) m_st = S_RUN;
        default: ;
      endcase
    end
    e.count   = to_bcd(m_val);
    e.running = (m_st == S_RUN);
    e.done    = m_done;
    q_exp.push_back(e);
  endtask

  task automatic apply(input bit ce, stop, load, start, pause, input logic [15:0] preset);
    @(negedge clk);
    bus.ce     = ce;
    bus.stop   = stop;
    bus.load   = load;
    bus.start  = start;
    bus.pause  = pause;
    bus.preset = preset;
    model_step(ce, stop, load, start, pause, preset);
    @(posedge clk);
    #1;
    bus.ce    = 1'b0;
    bus.stop  = 1'b0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    #2;
  endtask

  task automatic do_load(input logic [15:0] p);  apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p);  endtask
  task automatic do_start();                     apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0); endtask
  task automatic do_ce();                        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0); endtask
  task automatic do_idle();                      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0); endtask

  // Monitor: every cycle the DUT presents a new output word, compared against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        exp_t e;
        e = q_exp.pop_front();
        check("sb_count",   bus.count,           e.count);
        check("sb_running", {15'd0, bus.running}, {15'd0, e.running});
        check("sb_done",    {15'd0, bus.done},    {15'd0, e.done});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    reset      = 1'b1;
    bus.ce     = 1'b0;
    bus.stop   = 1'b0;
    bus.load   = 1'b0;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.preset = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",   bus.count,            16'h0000);
    check("rst_running", {15'd0, bus.running}, 16'h0000);
    check("rst_done",    {15'd0, bus.done},    16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // 01:05 down to 00:00
    do_load(16'h0105);
    do_start();
    for (int n = 1; n <= 65; n++) begin
      do_ce();
      if (n == 5)  check("t1_0100", bus.count, 16'h0100);
      if (n == 6)  check("t1_0059", bus.count, 16'h0059);
    end
    check("t1_zero",    bus.count,            16'h0000);
    check("t1_done_hi", {15'd0, bus.done},    16'h0001);
    check("t1_run_lo",  {15'd0, bus.running}, 16'h0000);
    do_idle();
    check("t1_done_lo", {15'd0, bus.done},    16'h0000);

    // start in DONE, then start from IDLE with zero count
    do_start();
    check("t3_done_start", {15'd0, bus.running}, 16'h0000);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    do_start();
    check("t3_idle_run",  {15'd0, bus.running}, 16'h0000);
    check("t3_idle_done", {15'd0, bus.done},    16'h0000);

    // borrow across several digits, then clamp on load
    do_load(16'h0910);
    do_start();
    repeat (11) do_ce();
    check("t2_0859", bus.count, 16'h0859);
    do_load(16'h0070);
    check("t2_clamp", bus.count, 16'h0050);

    // pause with simultaneous ce
    do_load(16'h0030);
    do_start();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    check("t4_pause_ce", bus.count, 16'h0030);
    repeat (3) do_ce();
    check("t4_paused", bus.count, 16'h0030);
    do_start();
    do_ce();
    check("t4_0029", bus.count, 16'h0029);

    // asynchronous reset between edges
    do_load(16'h0105);
    do_start();
    repeat (3) do_ce();
    check("t5_0102", bus.count, 16'h0102);
    #1;
    reset = 1'b1;
    #1;
    check("t5_arst_count",   bus.count,            16'h0000);
    check("t5_arst_running", {15'd0, bus.running}, 16'h0000);
    @(posedge clk);
    #1;
    check("t5_arst_hold", bus.count, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_load(16'h0105);
    do_start();
    do_ce();
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0222);
    check("t5_all_cmd",     bus.count,            16'h0000);
    check("t5_all_cmd_run", {15'd0, bus.running}, 16'h0000);

`ifdef TIMER_AUTORELOAD_EN
    do_load(16'h0003);
    do_start();
    repeat (3) do_ce();
    check("t6_reload",   bus.count,            16'h0003);
    check("t6_done",     {15'd0, bus.done},    16'h0001);
    check("t6_running",  {15'd0, bus.running}, 16'h0001);
    do_ce();
    check("t6_0002", bus.count, 16'h0002);
`endif

    // random command mix
    for (int n = 0; n < 800; n++) begin
      p = '0;
      p[3:0] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) p[7:4]   = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) p[11:8]  = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) p[15:12] = 4'($urandom_range(0, 9));
      apply($urandom_range(0, 1) == 1,
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0,
            p);
    end

    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
